// File: rtl/write_alert_logger_if.sv
// Alert-stream and readout bundle for write_alert_logger.
// master: the side that drives alerts and consumes log entries.
// slave:  the logger itself.
// Optional WRITE_ALERT_TIMESTAMP_EN adds the rd_timestamp signal.
interface write_alert_logger_if;

    // Upstream alert stream from the memory write monitor
    logic       alert_valid;
    logic [1:0] alert_module_id;
    logic [3:0] alert_addr;
    logic [3:0] alert_data;

    // First-word-fall-through readout
    logic       rd_ready;
    logic       rd_valid;
    logic [1:0] rd_module_id;
    logic [3:0] rd_addr;
    logic [3:0] rd_data;
`ifdef WRITE_ALERT_TIMESTAMP_EN
    logic [15:0] rd_timestamp;
`endif

    modport master (
        output alert_valid, alert_module_id, alert_addr, alert_data, rd_ready,
        input  rd_valid, rd_module_id, rd_addr, rd_data
`ifdef WRITE_ALERT_TIMESTAMP_EN
        , input rd_timestamp
`endif
    );

    modport slave (
        input  alert_valid, alert_module_id, alert_addr, alert_data, rd_ready,
        output rd_valid, rd_module_id, rd_addr, rd_data
`ifdef WRITE_ALERT_TIMESTAMP_EN
        , output rd_timestamp
`endif
    );

endinterface

// File: rtl/write_alert_logger.sv
// Converts level-held write alerts into discrete events, queues them in a
// first-word-fall-through FIFO, and tracks per-module saturating violation
// counters with sticky lockout flags for the bus-side write blocker.
// Define WRITE_ALERT_TIMESTAMP_EN to store a 16-bit cycle stamp per entry
// and expose it on bus.rd_timestamp.
module write_alert_logger #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned LOCK_THRESH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    write_alert_logger_if.slave      bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    input  logic [3:0]               clear_lockout,
    output logic [3:0]               lockout,
    output logic [4*CNT_W-1:0]       viol_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = 10;  // {module_id, addr, data}
`ifdef WRITE_ALERT_TIMESTAMP_EN
    localparam int unsigned EW = PW + 16;
`else
    localparam int unsigned EW = PW;
`endif

    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(LOCK_THRESH);

    // ------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------
    logic [PW-1:0] payload;
    logic          prev_valid_q;
    logic [PW-1:0] prev_payload_q;
    logic          new_event;

    assign payload = {bus.alert_module_id, bus.alert_addr, bus.alert_data};

    // A held alert logs once; a rising edge or a payload change is a new event.
    assign new_event = bus.alert_valid &&
                       (!prev_valid_q || (payload != prev_payload_q));

    // History of last cycle's alert, sampled every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_valid_q   <= 1'b0;
            prev_payload_q <= '0;
        end else begin
            prev_valid_q   <= bus.alert_valid;
            prev_payload_q <= payload;
        end
    end

    // ------------------------------------------------------------------
    // Optional free-running timestamp
    // ------------------------------------------------------------------
    logic [EW-1:0] entry;

`ifdef WRITE_ALERT_TIMESTAMP_EN
    logic [15:0] ts_q;

    // Free-running cycle counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 16'd1;
        end
    end

    assign entry = {ts_q, payload};
`else
    assign entry = payload;
`endif

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          not_empty;
    logic          push;
    logic          pop;
    logic          drop;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign pop       = not_empty && bus.rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = new_event && (!full || pop);
    assign drop      = new_event && full && !pop;

    // Pointer and occupancy next-state; pointers wrap since DEPTH is 2^AW
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until covered by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    // ------------------------------------------------------------------
    // Drop tracking
    // ------------------------------------------------------------------
    logic       overflow_q;
    logic [7:0] drop_cnt_q;

    // Sticky overflow and saturating drop counter; only rst clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-module violation counters and lockout
    // ------------------------------------------------------------------
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]            lock_q, lock_d;

    // Count every event, logged or dropped; clear beats a same-cycle increment
    always_comb begin
        cnt_d  = cnt_q;
        lock_d = lock_q;
        for (int k = 0; k < 4; k++) begin
            if (clear_lockout[k]) begin
                cnt_d[k]  = '0;
                lock_d[k] = 1'b0;
            end else if (new_event && (bus.alert_module_id == 2'(k)) &&
                         (cnt_q[k] != CNT_MAX)) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
                if (cnt_d[k] == THRESH) begin
                    lock_d[k] = 1'b1;
                end
            end
        end
    end

    // Counter and lockout registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            lock_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [EW-1:0] head;

    // Head entry, forced to zero while empty
    always_comb begin
        head = '0;
        if (not_empty) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign bus.rd_valid     = not_empty;
    assign bus.rd_module_id = head[9:8];
    assign bus.rd_addr      = head[7:4];
    assign bus.rd_data      = head[3:0];
`ifdef WRITE_ALERT_TIMESTAMP_EN
    assign bus.rd_timestamp = head[EW-1:PW];
`endif

    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;
    assign lockout    = lock_q;
    assign viol_count = cnt_q;

endmodule

// File: tb/tb_write_alert_logger.sv
// Directed, table-driven bench for write_alert_logger (default build).
module tb_write_alert_logger;

    logic        clk;
    logic        rst;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [3:0]  clear_lockout;
    logic [3:0]  lockout;
    logic [15:0] viol_count;

    int total = 0;
    int bad   = 0;

    write_alert_logger_if bus ();

    write_alert_logger #(
        .DEPTH      (8),
        .CNT_W      (4),
        .LOCK_THRESH(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .clear_lockout(clear_lockout),
        .lockout      (lockout),
        .viol_count   (viol_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [1:0]  id;
        logic [3:0]  addr;
        logic [3:0]  data;
        logic        rdy;
        logic [3:0]  clr;
        logic        e_vld;
        logic [9:0]  e_head;
        logic [3:0]  e_cnt;
        logic        e_ovf;
        logic [7:0]  e_drops;
        logic [3:0]  e_lock;
        logic [15:0] e_viol;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] hd(input logic [1:0] id, input logic [3:0] a,
                                      input logic [3:0] d);
        return {id, a, d};
    endfunction

    function automatic void add(input logic av, input logic [1:0] id, input logic [3:0] a,
                                input logic [3:0] d, input logic rdy, input logic [3:0] clr,
                                input logic vld, input logic [9:0] head, input logic [3:0] cnt,
                                input logic ovf, input logic [7:0] drops,
                                input logic [3:0] lock, input logic [15:0] viol);
        vec_t v;
        v.av = av; v.id = id; v.addr = a; v.data = d; v.rdy = rdy; v.clr = clr;
        v.e_vld = vld; v.e_head = head; v.e_cnt = cnt; v.e_ovf = ovf;
        v.e_drops = drops; v.e_lock = lock; v.e_viol = viol;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic vld, input logic [9:0] head,
                               input logic [3:0] cnt, input logic ovf, input logic [7:0] drops,
                               input logic [3:0] lock, input logic [15:0] viol);
        check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(vld));
        check({tag, ".rd_head"}, 32'({bus.rd_module_id, bus.rd_addr, bus.rd_data}),
              32'(head));
        check({tag, ".fifo_count"}, 32'(fifo_count), 32'(cnt));
        check({tag, ".overflow"}, 32'(overflow), 32'(ovf));
        check({tag, ".drop_count"}, 32'(drop_count), 32'(drops));
        check({tag, ".lockout"}, 32'(lockout), 32'(lock));
        check({tag, ".viol_count"}, 32'(viol_count), 32'(viol));
    endtask

    task automatic drive(input logic av, input logic [1:0] id, input logic [3:0] a,
                         input logic [3:0] d, input logic rdy, input logic [3:0] clr);
        bus.alert_valid     = av;
        bus.alert_module_id = id;
        bus.alert_addr      = a;
        bus.alert_data      = d;
        bus.rd_ready        = rdy;
        clear_lockout       = clr;
    endtask

    // Advance one edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // Single event held 5 cycles, then payload change, then drain
        for (int i = 0; i < 5; i++) add(1, 1, 3, 5, 0, 0, 1, hd(1, 3, 5), 1, 0, 0, 0, 16'h0010);
        add(1, 1, 3, 6, 0, 0,    1, hd(1, 3, 5), 2, 0, 0, 0, 16'h0020);
        add(0, 0, 0, 0, 1, 0,    1, hd(1, 3, 6), 1, 0, 0, 0, 16'h0020);
        add(0, 0, 0, 0, 1, 0,    0, 10'h0,       0, 0, 0, 0, 16'h0020);
        // Three id=2 pulses reach the lockout threshold
        add(1, 2, 1, 1, 0, 0,    1, hd(2, 1, 1), 1, 0, 0, 0,     16'h0120);
        add(0, 0, 0, 0, 0, 0,    1, hd(2, 1, 1), 1, 0, 0, 0,     16'h0120);
        add(1, 2, 1, 1, 0, 0,    1, hd(2, 1, 1), 2, 0, 0, 0,     16'h0220);
        add(0, 0, 0, 0, 0, 0,    1, hd(2, 1, 1), 2, 0, 0, 0,     16'h0220);
        add(1, 2, 1, 1, 0, 0,    1, hd(2, 1, 1), 3, 0, 0, 4'h4,  16'h0320);
        add(0, 0, 0, 0, 0, 0,    1, hd(2, 1, 1), 3, 0, 0, 4'h4,  16'h0320);
        // Clear coincident with a 4th id=2 event: entry logged, counter/lock cleared
        add(1, 2, 1, 1, 0, 4'h4, 1, hd(2, 1, 1), 4, 0, 0, 0,     16'h0020);
        add(0, 0, 0, 0, 1, 0,    1, hd(2, 1, 1), 3, 0, 0, 0,     16'h0020);
        // Multi-hot clear with no event
        add(0, 0, 0, 0, 0, 4'h3, 1, hd(2, 1, 1), 3, 0, 0, 0,     16'h0000);

        step();
        step();
        rst = 1'b0;
        check_state("reset", 0, 10'h0, 0, 0, 0, 0, 16'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].av, vecs[i].id, vecs[i].addr, vecs[i].data, vecs[i].rdy, vecs[i].clr);
            step();
            check_state($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_head, vecs[i].e_cnt,
                        vecs[i].e_ovf, vecs[i].e_drops, vecs[i].e_lock, vecs[i].e_viol);
        end

        // Counter saturation: 17 distinct id=3 events while draining
        for (int i = 0; i < 17; i++) begin
            drive(1, 3, 0, 4'(i), 1, 0);
            step();
        end
        check("sat.viol_count", 32'(viol_count), 32'h0000_F000);
        check("sat.lockout", 32'(lockout), 32'h8);
        drive(0, 0, 0, 0, 0, 4'h8);
        step();
        check("clr3.viol_count", 32'(viol_count), 32'h0);
        check("clr3.lockout", 32'(lockout), 32'h0);

        // Overflow: 10 back-to-back distinct events into an 8-deep FIFO
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 4'(i), 4'(i), 0, 0);
            step();
        end
        check_state("ovf", 1, hd(0, 0, 0), 8, 1, 2, 4'h1, 16'h000A);

        // Full with simultaneous pop: push accepted, no new drop
        drive(1, 0, 4'hF, 4'hF, 1, 0);
        step();
        check_state("fullpop", 1, hd(0, 1, 1), 8, 1, 2, 4'h1, 16'h000B);

        // Readout order
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("order%0d", i), 32'({bus.rd_module_id, bus.rd_addr, bus.rd_data}),
                  (i < 7) ? 32'(hd(0, 4'(i + 1), 4'(i + 1))) : 32'(hd(0, 4'hF, 4'hF)));
            step();
        end
        check_state("drained", 0, 10'h0, 0, 1, 2, 4'h1, 16'h000B);

        // Reset mid-stream with an alert held through release
        drive(0, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 4'(i), 4'(i), 0, 0);
            step();
        end
        check_state("prerst", 1, hd(1, 0, 0), 3, 1, 2, 4'h3, 16'h003B);
        rst = 1'b1;
        step();
        step();
        check_state("midrst", 0, 10'h0, 0, 0, 0, 0, 16'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_state("postrst", 1, hd(1, 2, 2), 1, 0, 0, 0, 16'h0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/write_alert_logger.md
Name: write_alert_logger

Overview:
- Sits directly downstream of the memory write monitor and consumes its alert stream: alert valid, offending module ID, write address and write data.
- Turns level-held alerts into discrete logged events and buffers them in a FIFO for a valid/ready readout interface.
- Keeps a saturating violation counter per module and raises a sticky lockout per module once that module reaches a threshold.
- Lockout bits feed the bus-side write blocking logic.

Parameters:
- DEPTH, 8: FIFO entries; power of two, >= 2.
- CNT_W, 4: width of each per-module violation counter.
- LOCK_THRESH, 3: counter value at which the module's lockout bit sets; range 1 .. 2^CNT_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alert_valid  in  1  upstream alert active (level)
- alert_module_id  in  2  offending module ID
- alert_addr  in  4  offending write address
- alert_data  in  4  offending write data
- rd_ready  in  1  consumer accepts head entry
- rd_valid  out  1  FIFO non-empty
- rd_module_id  out  2  head entry module ID
- rd_addr  out  4  head entry address
- rd_data  out  4  head entry data
- fifo_count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky; set when an event is dropped
- drop_count  out  8  dropped events, saturates at 255
- clear_lockout  in  4  one-hot/multi-hot per-module clear pulse
- lockout  out  4  per-module lockout flags
- viol_count  out  4*CNT_W  packed counters; module k in bits [k*CNT_W +: CNT_W]

Behaviour:
- Reset (rst=1 at posedge clk): pointers, fifo_count, overflow, drop_count, all viol counters and lockout clear to 0. rd_valid=0. rd_module_id/rd_addr/rd_data=0. Event-detect history register cleared.
- Event detection:
  - A new event occurs in a cycle where alert_valid=1 AND either (alert_valid was 0 last cycle) OR ({module_id,addr,data} differs from last cycle's sampled payload).
  - A held identical alert logs once only.
  - History (prev valid, prev payload) is registered every cycle.
- Push: on a new event, the entry {module_id,addr,data} is written at the edge it is sampled. rd_valid asserts the cycle after that edge if the FIFO was empty (1-cycle latency).
- Pop: occurs when rd_valid && rd_ready at posedge. rd_* always present the head entry (first-word-fall-through). rd_* read 0 when empty.
- Full:
  - A new event with FIFO full and no pop in the same cycle is dropped.
  - On a drop: overflow<=1; drop_count increments, saturating at 255.
  - With full and a simultaneous pop, the push is accepted and count stays DEPTH.
- Empty: pop is ignored (rd_valid=0). Simultaneous push+pop on empty is impossible, since rd_valid=0.
- Pointers wrap modulo DEPTH. fifo_count is push-minus-pop, 0..DEPTH.
- Counters:
  - On every new event (logged or dropped), viol_count[id] increments, saturating at 2^CNT_W-1.
  - When the incremented value equals LOCK_THRESH, lockout[id]<=1 at the same edge.
  - lockout is sticky.
- Clear: clear_lockout[k]=1 at posedge sets lockout[k]<=0 and viol_count[k]<=0. Clear wins over a same-cycle increment for module k.
- overflow/drop_count clear only on rst.
- rst asserted mid-operation discards all FIFO contents. The first alert after rst deasserts is treated as a rising edge.

Optional Feature:
- Macro: WRITE_ALERT_TIMESTAMP_EN.
- Defined:
  - A 16-bit free-running cycle counter (reset 0, wraps at 65535->0) is stored with each entry.
  - Output port rd_timestamp (out, 16) presents the head entry's timestamp, or 0 when empty.
  - The timestamp stored is the counter value at the push edge.
- Undefined: no counter, no rd_timestamp port; all other behaviour identical.

Test Plan:
- Single event: after reset, alert_valid=1 for 5 cycles with id=1, addr=4'h3, data=4'h5, rd_ready=0 -> exactly one entry (fifo_count=1, rd_valid=1, rd_module_id=1, rd_addr=3, rd_data=5); viol_count[1]=1.
- Payload change while held: alert held, data changes 5->6 -> second entry logged; fifo_count=2.
- Overflow: DEPTH=8, rd_ready=0, 10 distinct events -> fifo_count=8, overflow=1, drop_count=2. Readout order matches the first 8 events.
- Full with pop: FIFO full, new event with rd_ready=1 in the same cycle -> event accepted, fifo_count stays 8, drop_count unchanged.
- Lockout: LOCK_THRESH=3, three separate pulses from id=2 -> lockout=4'b0100 at the third push edge. Then clear_lockout=4'b0100 coincident with a 4th id=2 event -> lockout=0, viol_count[2]=0.
- Reset mid-stream: 3 entries queued, rst pulse -> rd_valid=0, fifo_count=0, counters/lockout=0. An alert held through reset release is logged once.
